// File: rtl/uart_frame_rx_if.sv
`default_nettype none
// =============================================================================
// uart_frame_rx_if : byte-in / payload-out handshakes of uart_frame_rx
// Rev 1.0
// =============================================================================
interface uart_frame_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    // master: byte source upstream plus payload sink downstream
    modport master (
        output rx_data, rx_valid, out_ready,
        input  rx_ready, out_data, out_valid, out_last
    );

    // slave: the frame receiver itself
    modport slave (
        input  rx_data, rx_valid, out_ready,
        output rx_ready, out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// =============================================================================
// uart_frame_rx : SYNC/LEN/payload/CHK frame receiver with checksum gate
// Rev 1.0
// =============================================================================
module uart_frame_rx #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    MAX_LEN       = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = 8'hA5,
    parameter int                    CLK_FREQ      = 50_000_000,
    parameter int                    BAUD_RATE     = 115_200,
    parameter int                    TIMEOUT_BYTES = 4
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic         ena,
    uart_frame_rx_if.slave    bus,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code
);
    localparam int C_LIMIT = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW      = $clog2(C_LIMIT + 1);
    localparam logic [DATA_WIDTH-1:0] C_MAX_LEN = DATA_WIDTH'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t                r_state;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_wr_idx;
    logic [LW-1:0]         r_rd_idx;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [TW-1:0]         r_tcnt;
    logic [DATA_WIDTH-1:0] r_mem [MAX_LEN];
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_frame_ok;
    logic                  r_frame_err;
    logic [1:0]            r_err_code;

    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_in_frame;
    logic                  w_timeout;
    logic [LW-1:0]         w_rd_next;

    assign bus.rx_ready = ena && (r_state != S_DRAIN);
    assign w_accept     = bus.rx_valid && bus.rx_ready;
    assign w_xfer       = ena && r_out_valid && bus.out_ready;
    assign w_in_frame   = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    assign w_timeout    = ena && w_in_frame && !w_accept && (r_tcnt == TW'(C_LIMIT - 1));
    assign w_rd_next    = r_rd_idx + LW'(1);

    // Handshake and pulse outputs are masked while the block is frozen
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid && ena;
    assign bus.out_last  = r_out_last;
    assign frame_ok      = r_frame_ok && ena;
    assign frame_err     = r_frame_err && ena;
    assign err_code      = r_err_code;

    always_ff @(posedge clk) begin
        if (w_accept && (r_state == S_PAYLOAD)) begin
            r_mem[r_wr_idx[AW-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_sum       <= '0;
            r_tcnt      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            if (ena) begin
                if (w_accept) begin
                    r_tcnt <= '0;
                end else if (w_in_frame) begin
                    r_tcnt <= r_tcnt + TW'(1);
                end

                if (w_timeout) begin
                    r_frame_err <= 1'b1;
                    r_err_code  <= 2'd3;
                    r_state     <= S_IDLE;
                    r_tcnt      <= '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_accept && (bus.rx_data == SYNC_BYTE)) begin
                                r_state <= S_LEN;
                            end
                        end
                        S_LEN: begin
                            if (w_accept) begin
                                if ((bus.rx_data == '0) || (bus.rx_data > C_MAX_LEN)) begin
                                    r_frame_err <= 1'b1;
                                    r_err_code  <= 2'd1;
                                    r_state     <= S_IDLE;
                                end else begin
                                    r_len    <= bus.rx_data[LW-1:0];
                                    r_sum    <= bus.rx_data;
                                    r_wr_idx <= '0;
                                    r_state  <= S_PAYLOAD;
                                end
                            end
                        end
                        S_PAYLOAD: begin
                            if (w_accept) begin
                                r_wr_idx <= r_wr_idx + LW'(1);
                                r_sum    <= r_sum + bus.rx_data;
                                if (r_wr_idx == (r_len - LW'(1))) begin
                                    r_state <= S_CHK;
                                end
                            end
                        end
                        S_CHK: begin
                            if (w_accept) begin
                                if (bus.rx_data == r_sum) begin
                                    // Present the first payload byte together with frame_ok
                                    r_frame_ok  <= 1'b1;
                                    r_out_valid <= 1'b1;
                                    r_out_data  <= r_mem[0];
                                    r_out_last  <= (r_len == LW'(1));
                                    r_rd_idx    <= '0;
                                    r_state     <= S_DRAIN;
                                end else begin
                                    r_frame_err <= 1'b1;
                                    r_err_code  <= 2'd2;
                                    r_state     <= S_IDLE;
                                end
                            end
                        end
                        S_DRAIN: begin
                            if (w_xfer) begin
                                if (r_out_last) begin
                                    r_out_valid <= 1'b0;
                                    r_out_last  <= 1'b0;
                                    r_state     <= S_IDLE;
                                end else begin
                                    r_rd_idx   <= w_rd_next;
                                    r_out_data <= r_mem[w_rd_next[AW-1:0]];
                                    r_out_last <= (w_rd_next == (r_len - LW'(1)));
                                end
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// =============================================================================
// tb_uart_frame_rx : directed frames with hand-computed expected outputs
// Rev 1.0
// =============================================================================
module tb_uart_frame_rx;
    logic       clk;
    logic       reset_n;
    logic       ena;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    int         n_tests;
    int         n_fail;
    int         n_err_pulses;
    int         n_ok_pulses;

    uart_frame_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_frame_rx #(
        .DATA_WIDTH   (8),
        .MAX_LEN      (16),
        .SYNC_BYTE    (8'hA5),
        .CLK_FREQ     (50_000_000),
        .BAUD_RATE    (115_200),
        .TIMEOUT_BYTES(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ena      (ena),
        .bus      (bus),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) n_err_pulses++;
        if (frame_ok)  n_ok_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte for exactly one accepting edge; returns 1 time unit after it
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    // Checks the currently presented payload byte, then lets it transfer
    task automatic expect_out(input string tag, input logic [7:0] d, input logic last);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"},  32'(bus.out_data),  32'(d));
        check({tag, "_last"},  32'(bus.out_last),  32'(last));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int errs_before;
        int bp_bad;
        n_tests = 0; n_fail = 0; n_err_pulses = 0; n_ok_pulses = 0;
        reset_n = 1'b0; ena = 1'b1;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready",  32'(bus.rx_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'h00);
        check("rst_frame_ok",  32'(frame_ok),      32'd0);
        check("rst_frame_err", 32'(frame_err),     32'd0);
        check("rst_err_code",  32'(err_code),      32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Nominal frame: 03+11+22+33 = 69
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        check("nom_frame_ok", 32'(frame_ok), 32'd1);
        expect_out("nom_b0", 8'h11, 1'b0);
        check("nom_ok_pulse_width", 32'(frame_ok), 32'd0);
        expect_out("nom_b1", 8'h22, 1'b0);
        expect_out("nom_b2", 8'h33, 1'b1);
        check("nom_done_valid", 32'(bus.out_valid), 32'd0);
        check("nom_rx_ready_back", 32'(bus.rx_ready), 32'd1);

        // Garbage is dropped silently; 01+7E = 7F
        errs_before = n_err_pulses;
        send(8'h00); send(8'hFF); send(8'h5A);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        check("garb_frame_ok", 32'(frame_ok), 32'd1);
        expect_out("garb_b0", 8'h7E, 1'b1);
        check("garb_no_err", 32'(n_err_pulses - errs_before), 32'd0);

        // Bad checksum (correct would be 32), then a good frame
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        check("chk_frame_err", 32'(frame_err), 32'd1);
        check("chk_err_code",  32'(err_code),  32'd2);
        check("chk_no_valid",  32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("chk_err_pulse_width", 32'(frame_err), 32'd0);
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
        check("chk2_frame_ok", 32'(frame_ok), 32'd1);
        expect_out("chk2_b0", 8'h10, 1'b0);
        expect_out("chk2_b1", 8'h20, 1'b1);

        // Bad lengths, then SYNC inside payload: 01+A5 = A6
        send(8'hA5); send(8'h00);
        check("len0_err",  32'(frame_err), 32'd1);
        check("len0_code", 32'(err_code),  32'd1);
        send(8'hA5); send(8'h11);
        check("len17_err",  32'(frame_err), 32'd1);
        check("len17_code", 32'(err_code),  32'd1);
        send(8'hA5); send(8'h01); send(8'hA5); send(8'hA6);
        check("len_next_ok", 32'(frame_ok), 32'd1);
        expect_out("sync_in_payload", 8'hA5, 1'b1);
        check("err_code_held", 32'(err_code), 32'd1);

        // Timeout: 17360 cycles after the last accepted byte
        send(8'hA5); send(8'h02); send(8'h10);
        repeat (17359) @(posedge clk);
        #1;
        check("to_not_early", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        check("to_err",  32'(frame_err), 32'd1);
        check("to_code", 32'(err_code),  32'd3);
        // 03+01+02+03 = 09
        send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h09);
        check("to_next_ok", 32'(frame_ok), 32'd1);
        expect_out("to_b0", 8'h01, 1'b0);
        expect_out("to_b1", 8'h02, 1'b0);
        expect_out("to_b2", 8'h03, 1'b1);

        // Backpressure: 02+AB+CD = 17A -> 7A
        bus.out_ready = 1'b0;
        send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h7A);
        bp_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hAB ||
                bus.out_last !== 1'b0 || bus.rx_ready !== 1'b0) bp_bad++;
            @(posedge clk); #1;
        end
        check("bp_stable", 32'(bp_bad), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        expect_out("bp_b1", 8'hCD, 1'b1);
        check("bp_done_ready", 32'(bus.rx_ready), 32'd1);

        // Enable low mid-payload: 04+01+02+03+04 = 0E
        errs_before = n_err_pulses;
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        @(negedge clk);
        ena = 1'b0;
        #1;
        check("ena_rx_ready_low", 32'(bus.rx_ready), 32'd0);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        ena = 1'b1;
        bus.out_ready = 1'b0;
        send(8'h03); send(8'h04); send(8'h0E);
        check("ena_no_timeout", 32'(n_err_pulses - errs_before), 32'd0);
        check("ena_frame_ok", 32'(frame_ok), 32'd1);
        @(negedge clk);
        ena = 1'b0;
        #1;
        check("ena_valid_forced_low", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        ena = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        expect_out("ena_b0", 8'h01, 1'b0);
        expect_out("ena_b1", 8'h02, 1'b0);
        expect_out("ena_b2", 8'h03, 1'b0);
        expect_out("ena_b3", 8'h04, 1'b1);

        // Reset during drain: 01+55 = 56
        bus.out_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h55); send(8'h56);
        check("mr_valid_before", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mr_valid",    32'(bus.out_valid), 32'd0);
        check("mr_data",     32'(bus.out_data),  32'h00);
        check("mr_err_code", 32'(err_code),      32'd0);
        check("mr_rx_ready", 32'(bus.rx_ready),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        // 01+42 = 43
        send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
        check("mr_next_ok", 32'(frame_ok), 32'd1);
        expect_out("mr_b0", 8'h42, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_frame_rx.md
# uart_frame_rx

Length-framed packet receiver sitting directly downstream of the `uart` receive port. Consumes the `rx_data`/`rx_valid` byte stream, hunts for a sync byte, captures a length-prefixed payload into an internal buffer, and verifies an 8-bit additive checksum. It releases the payload as a valid/ready byte stream with an end-of-frame marker only after the checksum passes. Bad frames are discarded and reported with an error code.

## Interface
- `DATA_WIDTH`, 8: byte width; fixed at 8, other values unsupported.
- `MAX_LEN`, 16: maximum payload bytes per frame. Also the buffer depth.
- `SYNC_BYTE`, 8'hA5: start-of-frame marker.
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate.
- `TIMEOUT_BYTES`, 4: inter-byte timeout, in character times.
- `clk`  in  1  single clock; all logic rising-edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `ena`  in  1  block enable; low freezes all state and counters.
- `rx_data`  in  8  byte from uart receiver.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  block accepts a byte this cycle.
- `out_data`  out  8  payload byte.
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  marks the final payload byte of the frame.
- `out_ready`  in  1  downstream accepts a byte.
- `frame_ok`  out  1  one-cycle pulse: frame passed its checksum.
- `frame_err`  out  1  one-cycle pulse: frame was discarded.
- `err_code`  out  2  1 = bad LEN, 2 = checksum mismatch, 3 = timeout. Held until the next `frame_err`.

## Operation
- Frame format: SYNC, LEN, LEN payload bytes, CHK.
  - LEN valid range is 1..MAX_LEN.
  - CHK = (LEN + Σpayload) mod 256.
- A byte is accepted on a rising edge where `rx_valid && rx_ready`.
- `rx_ready` is combinational: `ena && state != DRAIN`.
- States:
  - IDLE: accepted bytes other than SYNC_BYTE are discarded silently. SYNC_BYTE → LEN.
  - LEN:
    - LEN = 0 or LEN > MAX_LEN: `frame_err`, code 1 → IDLE.
    - Otherwise: store LEN, set sum = LEN, clear write index → PAYLOAD.
  - PAYLOAD:
    - Each byte is written to buf[wr_idx]; wr_idx increments; sum += byte (8-bit, wraps).
    - After LEN bytes → CHK.
    - SYNC_BYTE inside the payload is treated as data.
  - CHK:
    - Byte == sum: `frame_ok` → DRAIN.
    - Byte != sum: `frame_err`, code 2 → IDLE.
  - DRAIN:
    - `out_data` = buf[rd_idx]; `out_valid` = 1; `out_last` = (rd_idx == LEN-1).
    - Each `out_valid && out_ready` advances rd_idx.
    - The transfer with `out_last` → IDLE.
- Timeout:
  - Counter limit = TIMEOUT_BYTES × 10 × (CLK_FREQ / BAUD_RATE), integer division (17360 at defaults).
  - The counter runs in LEN, PAYLOAD and CHK, and clears on every accepted byte.
  - Reaching the limit gives `frame_err`, code 3 → IDLE.
  - The counter is inactive in IDLE and DRAIN.
- `ena` low:
  - State, indices, sum, buffer and timeout counter hold.
  - `out_valid`, `frame_ok` and `frame_err` are forced low.
  - Operation resumes unchanged when `ena` returns high.
- Reset mid-frame or mid-drain: the partial frame is lost and the block restarts in IDLE.
- Width of LEN and the indices: $clog2(MAX_LEN+1) bits. The LEN range check is done on the full 8-bit byte.

## Timing
- Reset values:
  - state IDLE.
  - `out_valid`, `out_last`, `frame_ok`, `frame_err` = 0.
  - `err_code` = 0; `out_data` = 0.
  - `rx_ready` = `ena`.
- The `frame_ok`/`frame_err` pulse is registered on the edge that accepts the deciding byte (or the timeout edge). It is high for exactly the following cycle.
- `out_valid` rises in the same cycle as `frame_ok`, i.e. 1 cycle after the CHK accept edge.
- Throughput: one payload byte per cycle while `out_ready` is high.
- `out_data` and `out_last` must stay stable while `out_valid && !out_ready`.
- `rx_ready` returns high in the cycle after the `out_last` transfer.
- `rx_valid` asserted while `rx_ready` is low: the byte is not consumed. Upstream is responsible for holding or dropping it.

## Test plan
- Nominal frame: A5 03 11 22 33 69 → `frame_ok` 1 cycle after the 69 accept; `out_data` 11, 22, 33 on consecutive cycles with `out_ready` = 1; `out_last` only on 33.
- Garbage then frame: 00 FF 5A, then A5 01 7E 7F → no `frame_err`; single output 7E with `out_last`.
- Bad checksum: A5 02 10 20 00 (correct CHK is 32) → `frame_err`, `err_code` = 2, no `out_valid`. A following good frame parses normally.
- Bad length:
  - A5 00 → code 1.
  - A5 11 (MAX_LEN+1) → code 1.
  - The next byte after either is hunted for SYNC.
- Timeout: A5 02 10, then idle for 17360 cycles → `frame_err`, code 3 on exactly that cycle. A subsequent valid frame is received intact.
- Backpressure and enable:
  - `out_ready` low for 10 cycles during DRAIN → `out_data` stable and `rx_ready` = 0.
  - `ena` low for 1000 cycles mid-PAYLOAD → no timeout; the frame completes correctly after `ena` returns high.
  - Reset asserted mid-DRAIN → all outputs at their reset values immediately.
